// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared types for the FC-layer sequencer: FSM states, pipeline
//            tag and the result-SRAM bank/word/lane decode.
// Revision : 1.0
// ============================================================================
package fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_t;

    // Tag index is fixed-width so the struct can live here; LEN_W must not exceed it.
    localparam int c_tag_idx_w = 16;

    typedef struct packed {
        logic                   first;
        logic                   last;
        logic [c_tag_idx_w-1:0] out_idx;
    } fc_tag_t;

    typedef struct packed {
        int unsigned bank;
        int unsigned word;
        int unsigned lane;
    } fc_wr_loc_t;

    // Neuron o lands in lane o%LANES of bank (o/LANES)%BANKS, word o/(LANES*BANKS).
    function automatic fc_wr_loc_t fc_decode(input int unsigned o,
                                             input int unsigned lanes,
                                             input int unsigned banks);
        fc_wr_loc_t loc;
        loc.lane = o % lanes;
        loc.bank = (o / lanes) % banks;
        loc.word = o / (lanes * banks);
        return loc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_sequencer_if
// Purpose  : Command/config, MAC control and result-write bundle of the
//            sequencer. master = sequencer side, slave = controller/fabric.
// Revision : 1.0
// ============================================================================
interface fc_layer_sequencer_if #(
    parameter int ACT_AW = 6,
    parameter int W_AW   = 15,
    parameter int OUT_AW = 6,
    parameter int LEN_W  = 10,
    parameter int LANES  = 4,
    parameter int BANKS  = 5
) ();
    logic              start;
    logic [LEN_W-1:0]  cfg_in_len;
    logic [LEN_W-1:0]  cfg_out_len;
    logic [W_AW-1:0]   cfg_w_base;
    logic              hold;
    logic              busy;
    logic              done;
    logic [ACT_AW-1:0] act_raddr;
    logic [W_AW-1:0]   w_raddr;
    logic              mac_en;
    logic              mac_clear;
    logic              mac_last;
    logic [BANKS-1:0]  wr_en;
    logic [OUT_AW-1:0] wr_addr;
    logic [LANES-1:0]  wr_mask;

    modport master (
        input  start, cfg_in_len, cfg_out_len, cfg_w_base, hold,
        output busy, done, act_raddr, w_raddr, mac_en, mac_clear, mac_last,
               wr_en, wr_addr, wr_mask
    );

    modport slave (
        output start, cfg_in_len, cfg_out_len, cfg_w_base, hold,
        input  busy, done, act_raddr, w_raddr, mac_en, mac_clear, mac_last,
               wr_en, wr_addr, wr_mask
    );
endinterface
`default_nettype wire

// File: rtl/fc_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fc_tag_pipe
// Purpose  : DEPTH-deep valid/tag delay line with synchronous clear; aligns
//            issue-side tags with data arriving at the MAC input.
// Revision : 1.0
// ============================================================================
module fc_tag_pipe
    import fc_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  fc_tag_t          in_tag,
    output logic             out_valid,
    output fc_tag_t          out_tag,
    output logic [DEPTH-1:0] valid_vec
);

    logic [DEPTH-1:0] r_valid;
    fc_tag_t          r_tag [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
            // Idle slots carry a zero tag so downstream clear/last never glitch.
            r_valid[0] <= in_valid;
            r_tag[0]   <= in_valid ? in_tag : '0;
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_tag   = r_tag[DEPTH-1];
    assign valid_vec = r_valid;

endmodule
`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_sequencer
// Purpose  : FC-layer address/control sequencer: streams activation/weight
//            addresses, drives MAC enable/clear/last, packs results bytewise
//            into banked SRAM. Option macro: FC_START_QUEUE_EN.
// Revision : 1.0
// ============================================================================
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int ACT_AW = 6,
    parameter int W_AW   = 15,
    parameter int OUT_AW = 6,
    parameter int LEN_W  = 10,
    parameter int LANES  = 4,
    parameter int BANKS  = 5,
    parameter int RD_LAT = 3
) (
    input  logic                 clk,
    input  logic                 srstn,
    fc_layer_sequencer_if.master bus
);

    localparam logic [RD_LAT-1:0] c_upstream_mask = {RD_LAT{1'b1}} >> 1;

    fc_state_t         r_state;
    fc_state_t         w_state_nxt;
    logic [LEN_W-1:0]  r_in_len;
    logic [LEN_W-1:0]  r_out_len;
    logic [LEN_W-1:0]  r_in_idx;
    logic [LEN_W-1:0]  r_out_idx;
    logic [W_AW-1:0]   r_w_ptr;
    logic              r_done;
    logic [BANKS-1:0]  r_wr_en;
    logic [OUT_AW-1:0] r_wr_addr;
    logic [LANES-1:0]  r_wr_mask;

    logic              w_launch;
    logic [LEN_W-1:0]  w_ld_in_len;
    logic [LEN_W-1:0]  w_ld_out_len;
    logic [W_AW-1:0]   w_ld_w_base;
    logic              w_issue;
    logic              w_last_in;
    logic              w_last_out;
    logic              w_drain_done;
    logic              w_pipe_clr;
    logic              w_pipe_valid;
    fc_tag_t           w_issue_tag;
    fc_tag_t           w_pipe_tag;
    logic [RD_LAT-1:0] w_pipe_vec;
    fc_wr_loc_t        w_loc;

`ifdef FC_START_QUEUE_EN
    logic              r_pend_vld;
    logic [LEN_W-1:0]  r_pend_in_len;
    logic [LEN_W-1:0]  r_pend_out_len;
    logic [W_AW-1:0]   r_pend_w_base;

    // A parked command has priority over a live start arriving in IDLE.
    assign w_launch     = (r_state == ST_IDLE) && (r_pend_vld || bus.start);
    assign w_ld_in_len  = r_pend_vld ? r_pend_in_len  : bus.cfg_in_len;
    assign w_ld_out_len = r_pend_vld ? r_pend_out_len : bus.cfg_out_len;
    assign w_ld_w_base  = r_pend_vld ? r_pend_w_base  : bus.cfg_w_base;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_pend_vld     <= 1'b0;
            r_pend_in_len  <= '0;
            r_pend_out_len <= '0;
            r_pend_w_base  <= '0;
        end else if (r_pend_vld) begin
            if (r_state == ST_IDLE) begin
                r_pend_vld <= 1'b0;
            end
        end else if (bus.start && (r_state != ST_IDLE)) begin
            r_pend_vld     <= 1'b1;
            r_pend_in_len  <= bus.cfg_in_len;
            r_pend_out_len <= bus.cfg_out_len;
            r_pend_w_base  <= bus.cfg_w_base;
        end
    end
`else
    assign w_launch     = (r_state == ST_IDLE) && bus.start;
    assign w_ld_in_len  = bus.cfg_in_len;
    assign w_ld_out_len = bus.cfg_out_len;
    assign w_ld_w_base  = bus.cfg_w_base;
`endif

    assign w_last_in  = (r_in_idx  == r_in_len  - LEN_W'(1));
    assign w_last_out = (r_out_idx == r_out_len - LEN_W'(1));

    // Nothing is issued in DRAIN, so a lone last term in the output stage is the final one.
    assign w_drain_done = w_pipe_valid && w_pipe_tag.last
                       && ((w_pipe_vec & c_upstream_mask) == '0);

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    if ((w_ld_in_len == '0) || (w_ld_out_len == '0)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!bus.hold) begin
                    w_issue = 1'b1;
                    if (w_last_in && w_last_out) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_in_len  <= '0;
            r_out_len <= '0;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_w_ptr   <= '0;
        end else if (w_launch) begin
            r_in_len  <= w_ld_in_len;
            r_out_len <= w_ld_out_len;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_w_ptr   <= w_ld_w_base;
        end else if (w_issue && !(w_last_in && w_last_out)) begin
            r_w_ptr <= r_w_ptr + W_AW'(1);
            if (w_last_in) begin
                r_in_idx  <= '0;
                r_out_idx <= r_out_idx + LEN_W'(1);
            end else begin
                r_in_idx  <= r_in_idx + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
        end
    end

    assign w_issue_tag.first   = (r_in_idx == '0);
    assign w_issue_tag.last    = w_last_in;
    assign w_issue_tag.out_idx = c_tag_idx_w'(r_out_idx);
    assign w_pipe_clr          = ~srstn;

    fc_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (w_pipe_clr),
        .in_valid  (w_issue),
        .in_tag    (w_issue_tag),
        .out_valid (w_pipe_valid),
        .out_tag   (w_pipe_tag),
        .valid_vec (w_pipe_vec)
    );

    assign w_loc = fc_decode(32'(w_pipe_tag.out_idx), LANES, BANKS);

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_mask <= '0;
        end else if (w_pipe_valid && w_pipe_tag.last) begin
            r_wr_en   <= BANKS'(1) << w_loc.bank;
            r_wr_addr <= OUT_AW'(w_loc.word);
            r_wr_mask <= (LANES'(1) << (LANES - 1)) >> w_loc.lane;
        end else begin
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_mask <= '0;
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.act_raddr = ACT_AW'(r_in_idx);
    assign bus.w_raddr   = r_w_ptr;
    assign bus.mac_en    = w_pipe_valid;
    assign bus.mac_clear = w_pipe_valid & w_pipe_tag.first;
    assign bus.mac_last  = w_pipe_valid & w_pipe_tag.last;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_mask   = r_wr_mask;

endmodule
`default_nettype wire
